// File: rtl/oled_pkg.sv
// Shared display constants, FSM state and source encodings for the OLED pixel scheduler.
package oled_pkg;

    localparam int OLED_WIDTH  = 96;
    localparam int OLED_HEIGHT = 64;

    localparam logic [15:0] COLOR_BLACK = 16'h0000;
    localparam logic [15:0] COLOR_WHITE = 16'hFFFF;

    typedef enum logic [1:0] {
        NORMAL = 2'd0,
        WIPE   = 2'd1,
        SAVER  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SRC_VOLUME = 2'd0,
        SRC_MENU   = 2'd1,
        SRC_SAVER  = 2'd2,
        SRC_WIPE   = 2'd3
    } source_t;

    // Rows past the panel never occur in a legal scan but are blanked all the same.
    function automatic logic on_screen(input logic [7:0] x, input logic [6:0] y, input int width);
        return (int'(x) < width) && (int'(y) < OLED_HEIGHT);
    endfunction

endpackage

// File: rtl/oled_source_scheduler_if.sv
// Pixel-stream bus between the colour generators, the scheduler and the OLED driver.
interface oled_source_scheduler_if;
    logic        tick_1hz;
    logic        frame_begin;
    logic [7:0]  coordinate_x;
    logic [6:0]  coordinate_y;
    logic        btn_activity;
    logic        menu_switch;
    logic        SW_2;
    logic [5:0]  volume_level;
    logic [15:0] menu_color;
    logic [15:0] volume_color;
    logic [15:0] saver_color;
    logic [15:0] oled_data;
    logic        saver_active;
    logic [1:0]  active_source;

    modport master (
        output tick_1hz, frame_begin, coordinate_x, coordinate_y, btn_activity,
               menu_switch, SW_2, volume_level, menu_color, volume_color, saver_color,
        input  oled_data, saver_active, active_source
    );

    modport slave (
        input  tick_1hz, frame_begin, coordinate_x, coordinate_y, btn_activity,
               menu_switch, SW_2, volume_level, menu_color, volume_color, saver_color,
        output oled_data, saver_active, active_source
    );
endinterface

// File: rtl/oled_source_scheduler_activity_detector.sv
// Turns buttons, menu-switch edges and large volume jumps into an activity pulse,
// and counts idle seconds since the last one.
module activity_detector #(
    parameter int IDLE_SECONDS = 10,
    parameter int VOL_DELTA    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_activity,
    input  logic       menu_switch,
    input  logic       tick_1hz,
    input  logic [5:0] volume_level,
    output logic       activity,
    output logic [7:0] idle_cnt
);

    logic              menu_prev;
    logic [5:0]        last_vol;
    logic signed [6:0] vol_diff;
    logic [6:0]        vol_mag;
    logic              vol_event;

    always_comb begin
        vol_diff  = $signed({1'b0, volume_level}) - $signed({1'b0, last_vol});
        vol_mag   = vol_diff[6] ? 7'(-vol_diff) : 7'(vol_diff);
        vol_event = (vol_mag >= 7'(VOL_DELTA));
        activity  = btn_activity || (menu_switch != menu_prev) || vol_event;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            menu_prev <= 1'b0;
            last_vol  <= '0;
            idle_cnt  <= '0;
        end else begin
            menu_prev <= menu_switch;
            // The reference level only moves on an accepted jump, so slow drift accumulates.
            if (vol_event)
                last_vol <= volume_level;
            if (activity)
                idle_cnt <= '0;
            else if (tick_1hz && (idle_cnt != 8'(IDLE_SECONDS)))
                idle_cnt <= idle_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/oled_source_scheduler.sv
// Chooses menu, volume or screensaver colour per pixel; screensaver entry wipes in
// column by column and every source change waits for a frame boundary.
module oled_source_scheduler
    import oled_pkg::*;
#(
    parameter int IDLE_SECONDS = 10,
    parameter int VOL_DELTA    = 4,
    parameter int WIPE_STEP    = 8,
    parameter int WIDTH        = OLED_WIDTH
) (
    input  logic                    clk12p5mhz_clk,
    input  logic                    rst_n,
    oled_source_scheduler_if.slave  bus
);

    state_t      state, state_next;
    logic [7:0]  wipe_col, wipe_next;
    logic [8:0]  wipe_sum;
    logic [7:0]  idle_cnt;
    logic        activity;
    logic        exit_pend;
    logic        exit_now;
    logic        enter_req;
    logic [15:0] normal_px, pixel;
    source_t     source;

    activity_detector #(
        .IDLE_SECONDS (IDLE_SECONDS),
        .VOL_DELTA    (VOL_DELTA)
    ) u_activity (
        .clk          (clk12p5mhz_clk),
        .rst_n        (rst_n),
        .btn_activity (bus.btn_activity),
        .menu_switch  (bus.menu_switch),
        .tick_1hz     (bus.tick_1hz),
        .volume_level (bus.volume_level),
        .activity     (activity),
        .idle_cnt     (idle_cnt)
    );

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        wipe_next  = wipe_col;
        enter_req  = (idle_cnt == 8'(IDLE_SECONDS)) && bus.SW_2;
        exit_now   = exit_pend || activity || !bus.SW_2;
        wipe_sum   = {1'b0, wipe_col} + 9'(WIPE_STEP);
        if (bus.frame_begin) begin
            unique case (state)
                NORMAL: if (enter_req) begin
                    state_next = WIPE;
                    wipe_next  = 8'(WIPE_STEP);
                end
                WIPE: if (exit_now) begin
                    state_next = NORMAL;
                    wipe_next  = '0;
                end else if (wipe_sum >= 9'(WIDTH)) begin
                    state_next = SAVER;
                end else begin
                    wipe_next  = wipe_sum[7:0];
                end
                SAVER: if (exit_now) begin
                    state_next = NORMAL;
                    wipe_next  = '0;
                end
                default: state_next = NORMAL;
            endcase
        end
    end

    always_comb begin
        normal_px = bus.menu_switch ? bus.menu_color : bus.volume_color;
        pixel     = normal_px;
        source    = bus.menu_switch ? SRC_MENU : SRC_VOLUME;
        unique case (state)
            WIPE: begin
                source = SRC_WIPE;
                if (bus.coordinate_x < wipe_col)
                    pixel = bus.saver_color;
            end
            SAVER: begin
                source = SRC_SAVER;
                pixel  = bus.saver_color;
            end
            default: ;
        endcase
        if (!on_screen(bus.coordinate_x, bus.coordinate_y, WIDTH))
            pixel = COLOR_BLACK;
    end

    // NOTE: all control flops are asynchronously reset; there is no memory array here to leave unreset.
    always_ff @(posedge clk12p5mhz_clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= NORMAL;
            wipe_col          <= '0;
            exit_pend         <= 1'b0;
            bus.oled_data     <= COLOR_BLACK;
            bus.active_source <= SRC_VOLUME;
            bus.saver_active  <= 1'b0;
        end else begin
            state    <= state_next;
            wipe_col <= wipe_next;
            // An exit requested mid-frame is remembered until the boundary that applies it.
            if (bus.frame_begin)
                exit_pend <= 1'b0;
            else if ((state != NORMAL) && (activity || !bus.SW_2))
                exit_pend <= 1'b1;
            bus.oled_data     <= pixel;
            bus.active_source <= source;
            bus.saver_active  <= (state != NORMAL);
        end
    end

endmodule
